// File: rtl/coeff_token_pipe_dec_if.sv
// Valid/ready handshake bundle for the coeff_token decoder: input window + nC, decoded token out.
interface coeff_token_pipe_dec_if #(
    parameter int unsigned WIN_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIN_W-1:0] in_bits;
    logic [5:0]       in_nc;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       out_tc;
    logic [1:0]       out_t1;
    logic [3:0]       out_len;
    logic             out_err;

    // Upstream/downstream side driving windows and consuming tokens
    modport master (
        output in_valid, in_bits, in_nc, out_ready,
        input  in_ready, out_valid, out_tc, out_t1, out_len, out_err
    );

    // Decoder side
    modport slave (
        input  in_valid, in_bits, in_nc, out_ready,
        output in_ready, out_valid, out_tc, out_t1, out_len, out_err
    );
endinterface

// File: rtl/coeff_token_pipe_dec.sv
// Two-stage coeff_token decoder (chroma-DC and 6-bit FLC tables) with a token counter.
// S1 captures the top window byte, nC class and leading-zero count; S2 does the lookup.
module coeff_token_pipe_dec #(
    parameter int unsigned WIN_W = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    coeff_token_pipe_dec_if.slave bus,
    input  logic                 clr_cnt,
    output logic [CNT_W-1:0]     tok_cnt
);
    localparam int unsigned TOP_W = 8;
    localparam int unsigned LZ_W  = 3;
    localparam int unsigned TC_W  = 5;
    localparam int unsigned T1_W  = 2;
    localparam int unsigned LEN_W = 4;

    typedef enum logic [1:0] {
        CLS_CDC   = 2'd0,
        CLS_FLC   = 2'd1,
        CLS_UNSUP = 2'd2
    } nc_cls_e;

    typedef struct packed {
        logic [TC_W-1:0]  tc;
        logic [T1_W-1:0]  t1;
        logic [LEN_W-1:0] len;
        logic             err;
    } tok_t;

    // Stage registers
    logic             s1_valid_q, s1_valid_d;
    logic [TOP_W-1:0] s1_bits_q, s1_bits_d;
    logic [LZ_W-1:0]  s1_lz_q, s1_lz_d;
    nc_cls_e          s1_cls_q, s1_cls_d;
    logic             out_valid_q, out_valid_d;
    tok_t             out_tok_q, out_tok_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             s1_adv_c;
    logic             s2_adv_c;
    logic [TOP_W-1:0] win_top_c;
    logic [LZ_W-1:0]  lz_c;
    nc_cls_e          cls_c;
    tok_t             dec_c;

    assign win_top_c = bus.in_bits[WIN_W-1 -: TOP_W];

    // Window bits below the top byte only exist for upstream alignment
    generate
        if (WIN_W > TOP_W) begin : g_low_bits
            logic unused_low_bits;
            assign unused_low_bits = ^bus.in_bits[WIN_W-TOP_W-1:0];
        end
    endgenerate

    // Ready chain: S2 frees when empty or draining, S1 frees when empty or moving into S2
    assign s2_adv_c     = !out_valid_q || bus.out_ready;
    assign s1_adv_c     = !s1_valid_q || s2_adv_c;
    assign bus.in_ready = s1_adv_c;

    // Leading-zero count of the top byte, saturating at 7
    always_comb begin
        lz_c = 3'd7;
        casez (win_top_c)
            8'b1???????: lz_c = 3'd0;
            8'b01??????: lz_c = 3'd1;
            8'b001?????: lz_c = 3'd2;
            8'b0001????: lz_c = 3'd3;
            8'b00001???: lz_c = 3'd4;
            8'b000001??: lz_c = 3'd5;
            8'b0000001?: lz_c = 3'd6;
            default:     lz_c = 3'd7;
        endcase
    end

    // nC class: -1 is chroma DC, >= 8 is the fixed-length table, everything else unsupported
    always_comb begin
        cls_c = CLS_UNSUP;
        if (bus.in_nc == 6'h3F) begin
            cls_c = CLS_CDC;
        end else if (!bus.in_nc[5] && (bus.in_nc[4:3] != 2'b00)) begin
            cls_c = CLS_FLC;
        end
    end

    // S1 next state: capture a new window whenever the stage can advance
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_bits_d  = s1_bits_q;
        s1_lz_d    = s1_lz_q;
        s1_cls_d   = s1_cls_q;
        if (s1_adv_c) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_bits_d = win_top_c;
                s1_lz_d   = lz_c;
                s1_cls_d  = cls_c;
            end
        end
    end

    // S2 table lookup from the S1 registers; errors force the payload to zero
    always_comb begin
        logic [3:0] flc_x;
        logic [1:0] flc_y;
        dec_c = '0;
        flc_x = s1_bits_q[7:4];
        flc_y = s1_bits_q[3:2];
        unique case (s1_cls_q)
            CLS_CDC: begin
                unique case (s1_lz_q)
                    3'd0: dec_c = '{tc: 5'd1, t1: 2'd1, len: 4'd1, err: 1'b0};
                    3'd1: dec_c = '{tc: 5'd0, t1: 2'd0, len: 4'd2, err: 1'b0};
                    3'd2: dec_c = '{tc: 5'd2, t1: 2'd2, len: 4'd3, err: 1'b0};
                    3'd3: begin
                        unique case (s1_bits_q[3:2])
                            2'b00:   dec_c = '{tc: 5'd2, t1: 2'd0, len: 4'd6, err: 1'b0};
                            2'b01:   dec_c = '{tc: 5'd3, t1: 2'd3, len: 4'd6, err: 1'b0};
                            2'b10:   dec_c = '{tc: 5'd2, t1: 2'd1, len: 4'd6, err: 1'b0};
                            default: dec_c = '{tc: 5'd1, t1: 2'd0, len: 4'd6, err: 1'b0};
                        endcase
                    end
                    3'd4: begin
                        if (s1_bits_q[2]) dec_c = '{tc: 5'd3, t1: 2'd0, len: 4'd6, err: 1'b0};
                        else              dec_c = '{tc: 5'd4, t1: 2'd0, len: 4'd6, err: 1'b0};
                    end
                    3'd5: begin
                        if (s1_bits_q[1]) dec_c = '{tc: 5'd3, t1: 2'd1, len: 4'd7, err: 1'b0};
                        else              dec_c = '{tc: 5'd3, t1: 2'd2, len: 4'd7, err: 1'b0};
                    end
                    3'd6: begin
                        if (s1_bits_q[0]) dec_c = '{tc: 5'd4, t1: 2'd1, len: 4'd8, err: 1'b0};
                        else              dec_c = '{tc: 5'd4, t1: 2'd2, len: 4'd8, err: 1'b0};
                    end
                    default: dec_c = '{tc: 5'd4, t1: 2'd3, len: 4'd7, err: 1'b0};
                endcase
            end
            CLS_FLC: begin
                if ({flc_x, flc_y} == 6'b000011) begin
                    dec_c = '{tc: 5'd0, t1: 2'd0, len: 4'd6, err: 1'b0};
                end else begin
                    dec_c.tc  = TC_W'(flc_x) + 5'd1;
                    dec_c.t1  = flc_y;
                    dec_c.len = 4'd6;
                    dec_c.err = (TC_W'(flc_y) > dec_c.tc);
                end
            end
            default: dec_c.err = 1'b1;
        endcase
        if (dec_c.err) begin
            dec_c.tc  = '0;
            dec_c.t1  = '0;
            dec_c.len = '0;
        end
    end

    // S2 next state: load a decoded token when advancing, otherwise hold
    always_comb begin
        out_valid_d = out_valid_q;
        out_tok_d   = out_tok_q;
        if (s2_adv_c) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_tok_d = dec_c;
            end
        end
    end

    // Token counter: counts error-free deliveries, wraps, clear has priority
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (out_valid_q && bus.out_ready && !out_tok_q.err) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset empties both stages at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_bits_q   <= '0;
            s1_lz_q     <= '0;
            s1_cls_q    <= CLS_UNSUP;
            out_valid_q <= 1'b0;
            out_tok_q   <= '0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_bits_q   <= s1_bits_d;
            s1_lz_q     <= s1_lz_d;
            s1_cls_q    <= s1_cls_d;
            out_valid_q <= out_valid_d;
            out_tok_q   <= out_tok_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_tc    = out_tok_q.tc;
    assign bus.out_t1    = out_tok_q.t1;
    assign bus.out_len   = out_tok_q.len;
    assign bus.out_err   = out_tok_q.err;
    assign tok_cnt       = cnt_q;
endmodule
